ysyx_23060136_bpu_bht: RTL and testbench
========================================

YSYX_23060136_BPU_BHT -- requirements
Module: ysyx_23060136_BPU_BHT

Interface
REQ-001 SHALL have parameter BITS_W, default 32: PC/target width.
REQ-002 SHALL have parameter ENTRIES, default 16: table depth, a power of two ≥2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter TAG_W, default 8: stored tag width, requiring TAG_W+IDX_W+2 ≤ BITS_W.
REQ-004 SHALL have parameter CNT_W, default 2: saturating-counter width, ≥2.
REQ-005 SHALL have port clk  in  1: single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port IFU_pc  in  BITS_W: fetch PC to predict.
REQ-008 SHALL have port pred_take  out  1: predict taken.
REQ-009 SHALL have port pred_target  out  BITS_W: predicted next PC.
REQ-010 SHALL have port pred_ghr  out  IDX_W: history used for this prediction.
REQ-011 SHALL have port upd_valid  in  1: resolved B-type branch this cycle.
REQ-012 SHALL have port upd_pc  in  BITS_W: resolved branch PC.
REQ-013 SHALL have port upd_taken  in  1: actual outcome.
REQ-014 SHALL have port upd_target  in  BITS_W: actual taken target.
REQ-015 SHALL have port upd_ghr  in  IDX_W: pred_ghr carried down the pipe with the branch.
REQ-016 SHALL have port flush_all  in  1: invalidate the whole table.

Function
REQ-017 SHALL use idx(pc) = pc[IDX_W+1:2] and tag(pc) = pc[TAG_W+IDX_W+1:IDX_W+2].
REQ-018 SHALL hold, per entry, the registered fields valid, tag, cnt[CNT_W-1:0] and target.
REQ-019 SHALL define a prediction hit as valid & stored tag == tag(IFU_pc) at the read index.
REQ-020 SHALL, on a hit, drive pred_take = cnt MSB; otherwise pred_take = 0.
REQ-021 SHALL drive pred_target = stored target when pred_take = 1, else IFU_pc+4, with modulo-2^BITS_W wrap.
REQ-022 SHALL make the prediction combinational from registered state (zero latency).
REQ-023 SHALL make an update visible to prediction starting the cycle after upd_valid; a same-cycle read of the same entry returns the pre-update value.
REQ-024 SHALL, on an update hit, saturate-increment cnt when taken and saturate-decrement it when not taken, holding at all-ones and at 0.
REQ-025 SHALL, on an update hit with upd_taken = 1, write target = upd_target.
REQ-026 SHALL, on an update miss with upd_taken = 1, allocate the entry (overwriting any occupant): valid = 1, tag written, target written, cnt = 2^(CNT_W-1) (weakly taken).
REQ-027 SHALL, on an update miss with upd_taken = 0, leave the table unchanged.
REQ-028 SHALL, when flush_all is asserted, clear all valid bits at the next edge, and flush_all SHALL take priority over a simultaneous upd_valid.
REQ-029 SHALL make the update path purely synchronous, with no stall or handshake: one update is accepted per cycle.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously force all valid = 0, cnt = 2^(CNT_W-1)-1 (weakly not-taken), tag = 0, target = 0 and GHR = 0.
REQ-031 SHALL, when reset is asserted mid-update, discard that update.
REQ-032 SHALL drive pred_take = 0 and pred_ghr = 0 during reset.

Configuration
REQ-033 SHALL, with YSYX_23060136_BHT_GHR_EN defined, include an IDX_W-bit global history register (GHR).
REQ-034 SHALL, with YSYX_23060136_BHT_GHR_EN defined, use read index idx(IFU_pc) ^ GHR and drive pred_ghr = GHR.
REQ-035 SHALL, with YSYX_23060136_BHT_GHR_EN defined, use update index idx(upd_pc) ^ upd_ghr.
REQ-036 SHALL, with YSYX_23060136_BHT_GHR_EN defined, shift GHR on every upd_valid as GHR <= {GHR[IDX_W-2:0], upd_taken}.
REQ-037 SHALL, with YSYX_23060136_BHT_GHR_EN defined, clear GHR on flush_all.
REQ-038 SHALL, without YSYX_23060136_BHT_GHR_EN, use plain idx for both read and update, drive pred_ghr = 0, ignore upd_ghr and implement no GHR flops.

Verification
REQ-039 SHALL cover cold miss: after reset, IFU_pc=0x80000010 -> pred_take=0, pred_target=0x80000014.
REQ-040 SHALL cover allocation: upd_pc=0x80000010, taken, target 0x80000100 -> next cycle IFU_pc=0x80000010 gives pred_take=1, pred_target=0x80000100.
REQ-041 SHALL cover saturation (CNT_W=2): 5 taken updates -> cnt=3; then 1 not-taken -> still predicts taken; 2 more not-taken -> predicts not-taken; then 3 further not-taken -> cnt=0.
REQ-042 SHALL cover aliasing: allocate 0x80000010, then a taken update to 0x80000410 (same idx, different tag) -> 0x80000010 misses and 0x80000410 hits.
REQ-043 SHALL cover priority: flush_all with a simultaneous upd_valid taken -> all entries miss on the next cycle.
REQ-044 SHALL cover async reset: rst_n pulled low between edges -> pred_take=0 immediately; a prior hit entry misses after release.

Source files
------------

// File: rtl/ysyx_23060136_bpu_bht.sv
// Tagged branch history table: zero-latency prediction from registered state, one update per cycle.
// Optional gshare-style indexing is enabled by defining YSYX_23060136_BHT_GHR_EN.
module ysyx_23060136_bpu_bht #(
  parameter int BITS_W  = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS_W-1:0] IFU_pc,
  output logic              pred_take,
  output logic [BITS_W-1:0] pred_target,
  output logic [IDX_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [BITS_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [BITS_W-1:0] upd_target,
  input  logic [IDX_W-1:0]  upd_ghr,
  input  logic              flush_all
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] WEAK_NT = WEAK_T - CNT_W'(1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_d    [ENTRIES];
  logic [BITS_W-1:0]  target_q [ENTRIES];
  logic [BITS_W-1:0]  target_d [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic [CNT_W-1:0] wr_cnt;

  assign rd_tag = IFU_pc[TAG_W+IDX_W+1:IDX_W+2];
  assign wr_tag = upd_pc[TAG_W+IDX_W+1:IDX_W+2];

`ifdef YSYX_23060136_BHT_GHR_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign rd_idx   = IFU_pc[IDX_W+1:2] ^ ghr_q;
  assign wr_idx   = upd_pc[IDX_W+1:2] ^ upd_ghr;
  assign pred_ghr = ghr_q;

  // Truncating cast keeps the youngest IDX_W outcomes, and also covers IDX_W == 1.
  always_comb begin
    ghr_d = ghr_q;
    if (flush_all) begin
      ghr_d = '0;
    end else if (upd_valid) begin
      ghr_d = IDX_W'({ghr_q, upd_taken});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{IFU_pc, upd_pc};
`else
  assign rd_idx   = IFU_pc[IDX_W+1:2];
  assign wr_idx   = upd_pc[IDX_W+1:2];
  assign pred_ghr = '0;

  logic unused_ok;
  assign unused_ok = ^{IFU_pc, upd_pc, upd_ghr};
`endif

  // Prediction path: purely combinational from the registered table.
  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_take   = rd_hit && cnt_q[rd_idx][CNT_W-1];
  assign pred_target = pred_take ? target_q[rd_idx] : (IFU_pc + BITS_W'(4));

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign wr_cnt = cnt_q[wr_idx];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    if (flush_all) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (wr_hit) begin
        if (upd_taken) begin
          if (wr_cnt != CNT_MAX) begin
            cnt_d[wr_idx] = wr_cnt + CNT_W'(1);
          end
          target_d[wr_idx] = upd_target;
        end else if (wr_cnt != '0) begin
          cnt_d[wr_idx] = wr_cnt - CNT_W'(1);
        end
      end else if (upd_taken) begin
        // Miss on a taken branch evicts whatever occupies the slot.
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        cnt_d[wr_idx]    = WEAK_T;
        target_d[wr_idx] = upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        cnt_q[i]    <= WEAK_NT;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_bpu_bht.sv
// Directed bench for ysyx_23060136_bpu_bht in its default build (no global history).
module tb_ysyx_23060136_bpu_bht;

  logic        clk;
  logic        rst_n;
  logic [31:0] IFU_pc;
  logic        pred_take;
  logic [31:0] pred_target;
  logic [3:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [3:0]  upd_ghr;
  logic        flush_all;

  int n_assert;
  int n_fail;

  ysyx_23060136_bpu_bht dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IFU_pc     (IFU_pc),
    .pred_take  (pred_take),
    .pred_target(pred_target),
    .pred_ghr   (pred_ghr),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_ghr    (upd_ghr),
    .flush_all  (flush_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    step();
    upd_valid  = 1'b0;
  endtask

  task automatic pchk(input string tag, input logic [31:0] pc, input logic exp_take,
                      input logic [31:0] exp_tgt);
    IFU_pc = pc;
    #1;
    chk({tag, "_take"}, {31'd0, pred_take}, {31'd0, exp_take});
    chk({tag, "_tgt"}, pred_target, exp_tgt);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    IFU_pc     = 32'h8000_0010;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    upd_ghr    = 4'hA;
    flush_all  = 1'b0;

    #2;
    chk("rst_take", {31'd0, pred_take}, 32'd0);
    chk("rst_ghr", {28'd0, pred_ghr}, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    pchk("cold_miss", 32'h8000_0010, 1'b0, 32'h8000_0014);
    pchk("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Allocation; same-cycle read still sees the old contents.
    IFU_pc     = 32'h8000_0010;
    upd_valid  = 1'b1;
    upd_pc     = 32'h8000_0010;
    upd_taken  = 1'b1;
    upd_target = 32'h8000_0100;
    #1;
    chk("same_cycle_take", {31'd0, pred_take}, 32'd0);
    step();
    upd_valid = 1'b0;
    pchk("alloc", 32'h8000_0010, 1'b1, 32'h8000_0100);
    chk("ghr_zero", {28'd0, pred_ghr}, 32'd0);

    // Four more taken (five in total): counter saturates at 3.
    for (int i = 0; i < 4; i++) upd(32'h8000_0010, 1'b1, 32'h8000_0100);
    upd(32'h8000_0010, 1'b0, 32'h0);
    pchk("sat_nt1", 32'h8000_0010, 1'b1, 32'h8000_0100);
    upd(32'h8000_0010, 1'b0, 32'h0);
    upd(32'h8000_0010, 1'b0, 32'h0);
    pchk("sat_nt3", 32'h8000_0010, 1'b0, 32'h8000_0014);
    for (int i = 0; i < 3; i++) upd(32'h8000_0010, 1'b0, 32'h0);
    pchk("sat_nt6", 32'h8000_0010, 1'b0, 32'h8000_0014);
    // From 0 one taken reaches 1 (not taken); a second reaches 2 with a new target.
    upd(32'h8000_0010, 1'b1, 32'h8000_0200);
    pchk("floor_t1", 32'h8000_0010, 1'b0, 32'h8000_0014);
    upd(32'h8000_0010, 1'b1, 32'h8000_0200);
    pchk("floor_t2", 32'h8000_0010, 1'b1, 32'h8000_0200);

    // Same index, different tag: the new branch evicts the old one.
    upd(32'h8000_0410, 1'b1, 32'h8000_0300);
    pchk("alias_old", 32'h8000_0010, 1'b0, 32'h8000_0014);
    pchk("alias_new", 32'h8000_0410, 1'b1, 32'h8000_0300);
    upd(32'h8000_0010, 1'b0, 32'h8000_0700);
    pchk("miss_nt_keep", 32'h8000_0410, 1'b1, 32'h8000_0300);

    upd(32'h8000_0020, 1'b1, 32'h8000_0400);
    pchk("second_entry", 32'h8000_0020, 1'b1, 32'h8000_0400);

    // Flush wins over a simultaneous taken update.
    flush_all = 1'b1;
    upd(32'h8000_0030, 1'b1, 32'h8000_0600);
    flush_all = 1'b0;
    pchk("flush_a", 32'h8000_0410, 1'b0, 32'h8000_0414);
    pchk("flush_b", 32'h8000_0020, 1'b0, 32'h8000_0024);
    pchk("flush_c", 32'h8000_0030, 1'b0, 32'h8000_0034);

    // Async reset between edges, with an update pending across an edge in reset.
    upd(32'h8000_0040, 1'b1, 32'h8000_0500);
    pchk("pre_rst_hit", 32'h8000_0040, 1'b1, 32'h8000_0500);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_take", {31'd0, pred_take}, 32'd0);
    upd_valid  = 1'b1;
    upd_pc     = 32'h8000_0050;
    upd_taken  = 1'b1;
    upd_target = 32'h8000_0800;
    step();
    upd_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    pchk("post_rst_old", 32'h8000_0040, 1'b0, 32'h8000_0044);
    pchk("post_rst_disc", 32'h8000_0050, 1'b0, 32'h8000_0054);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
